// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port between the load/store unit and memory.
interface mem_access_unit_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
) ();
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic                 dmem_req;
  logic                 dmem_we;
  logic [AddrWidth-1:0] dmem_addr;
  logic [DataWidth-1:0] dmem_wdata;
  logic [StrbWidth-1:0] dmem_wstrb;
  logic                 dmem_ack;
  logic [DataWidth-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_wstrb,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_wstrb,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one req/ack transaction per access, formats
// store lanes, extracts and extends load data, stalls while a request is open.
module mem_access_unit #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exec_valid,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] store_data,
  output logic                 stall,
  mem_access_unit_if.master    dmem,
  output logic [DataWidth-1:0] data_mem_out,
  output logic                 load_valid,
  output logic                 misaligned
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0] wstrb_q, wstrb_d;
  logic                 is_load_q, is_load_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [1:0]           lane_q, lane_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 load_valid_q, load_valid_d;
  logic                 misaligned_q, misaligned_d;
  logic                 stall_c;

  logic                 op_present;
  logic                 op_store;
  logic                 op_legal;
  logic                 op_aligned;
  logic [DataWidth-1:0] fmt_wdata;
  logic [StrbWidth-1:0] fmt_wstrb;
  logic [DataWidth-1:0] load_shifted;
  logic [DataWidth-1:0] load_ext;

  // Decode the op offered by execute: legality, alignment and store lane format.
  always_comb begin
    op_present = exec_valid & (mem_read | mem_write);
    op_store   = mem_write;
    op_legal   = 1'b0;
    op_aligned = 1'b0;
    fmt_wdata  = store_data;
    fmt_wstrb  = '0;
    case (funct3)
      3'b000: begin
        op_legal   = 1'b1;
        op_aligned = 1'b1;
        fmt_wdata  = {StrbWidth{store_data[7:0]}};
        fmt_wstrb  = StrbWidth'(1) << addr[1:0];
      end
      3'b001: begin
        op_legal   = 1'b1;
        op_aligned = ~addr[0];
        fmt_wdata  = {(StrbWidth / 2){store_data[15:0]}};
        fmt_wstrb  = addr[1] ? StrbWidth'(4'b1100) : StrbWidth'(4'b0011);
      end
      3'b010: begin
        op_legal   = 1'b1;
        op_aligned = (addr[1:0] == 2'b00);
        fmt_wdata  = store_data;
        fmt_wstrb  = '1;
      end
      3'b100: begin
        op_legal   = ~op_store;
        op_aligned = 1'b1;
      end
      3'b101: begin
        op_legal   = ~op_store;
        op_aligned = ~addr[0];
      end
      default: begin
        op_legal = 1'b0;
      end
    endcase
  end

  // Align the returned word to the addressed lane and extend to full width.
  always_comb begin
    load_shifted = dmem.dmem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{(DataWidth - 8){load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_ext = {{(DataWidth - 16){load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_ext = DataWidth'(load_shifted[7:0]);
      3'b101:  load_ext = DataWidth'(load_shifted[15:0]);
      default: load_ext = load_shifted;
    endcase
  end

  // Next-state and output logic for the IDLE/REQ transaction sequencer.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    is_load_d    = is_load_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    data_d       = data_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    stall_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_present && op_legal) begin
          if (op_aligned) begin
            stall_c   = 1'b1;
            state_d   = REQ;
            req_d     = 1'b1;
            we_d      = op_store;
            addr_d    = {addr[AddrWidth-1:2], 2'b00};
            wdata_d   = fmt_wdata;
            wstrb_d   = op_store ? fmt_wstrb : '0;
            is_load_d = ~op_store;
            funct3_d  = funct3;
            lane_d    = addr[1:0];
          end else begin
            misaligned_d = 1'b1;
          end
        end
      end
      REQ: begin
        stall_c = ~dmem.dmem_ack;
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (is_load_q) begin
            data_d       = load_ext;
            load_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      data_q       <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      data_q       <= data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Stall is suppressed while reset is asserted so upstream never freezes in reset.
  assign stall           = rst_n & stall_c;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;
  assign data_mem_out    = data_q;
  assign load_valid      = load_valid_q;
  assign misaligned      = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a byte-level reference model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        exec_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] data_mem_out;
  logic        load_valid;
  logic        misaligned;

  mem_access_unit_if #(.DataWidth(32), .AddrWidth(32)) bus ();

  mem_access_unit #(.DataWidth(32), .AddrWidth(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exec_valid   (exec_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .stall        (stall),
    .dmem         (bus),
    .data_mem_out (data_mem_out),
    .load_valid   (load_valid),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  int          cyc;
  int          last_req_cyc;
  int          last_stalls;
  logic        exp_req;
  logic        exp_lv;
  logic        exp_mis;
  logic [31:0] exp_data;

  // Compare one observed value with its expectation and log a mismatch.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Access size in bytes from funct3.
  function automatic int unsigned op_size(input logic [2:0] f3);
    return 32'(1) << f3[1:0];
  endfunction

  // Byte enables: every byte covered by the access.
  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    int unsigned off;
    logic [3:0]  s;
    sz  = op_size(f3);
    off = a % 4;
    s   = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + sz) s[b] = 1'b1;
    end
    return s;
  endfunction

  // Write data: the low store bytes repeated across every lane.
  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int unsigned sz;
    logic [31:0] w;
    sz = op_size(f3);
    w  = '0;
    for (int b = 0; b < 4; b++) begin
      w[8*b +: 8] = sd[8*(b % sz) +: 8];
    end
    return w;
  endfunction

  // Load result: gather addressed bytes, then apply signed arithmetic if needed.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int unsigned sz;
    int unsigned off;
    longint      v;
    sz  = op_size(f3);
    off = a % 4;
    v   = 0;
    for (int k = 0; k < 4; k++) begin
      if (k < sz) v = v | (longint'(rd[8*(off+k) +: 8]) << (8*k));
    end
    if (!f3[2] && sz < 4 && ((v >> (8*sz - 1)) & 1) == 1) v = v - (longint'(1) << (8*sz));
    return 32'(v);
  endfunction

  // Advance to the next sampling point and check the cycle-level expectations.
  task automatic cycle_begin();
    @(negedge clk);
    cyc++;
    check_eq("dmem_req", 32'(bus.dmem_req), 32'(exp_req));
    check_eq("load_valid", 32'(load_valid), 32'(exp_lv));
    check_eq("misaligned", 32'(misaligned), 32'(exp_mis));
    check_eq("data_mem_out", data_mem_out, exp_data);
    exp_lv       = 1'b0;
    exp_mis      = 1'b0;
    exec_valid   = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  // One cycle with no memory instruction offered.
  task automatic idle();
    cycle_begin();
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
    #1;
    check_eq("stall_idle", 32'(stall), 32'd0);
  endtask

  // Offer one op and, if accepted, run it to ack with wt wait cycles.
  task automatic do_op(input logic ev, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input int wt,
                       input logic [31:0] rdv);
    logic        st;
    logic        legal;
    logic        aligned;
    int unsigned sz;
    st      = wr;
    sz      = op_size(f3);
    legal   = ev && (rd || wr) &&
              (st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5));
    aligned = (a % sz) == 0;
    cycle_begin();
    exec_valid       = ev;
    mem_read         = rd;
    mem_write        = wr;
    funct3           = f3;
    addr             = a;
    store_data       = sd;
    bus.dmem_rdata   = $urandom;
    #1;
    last_stalls = 0;
    if (!legal) begin
      check_eq("stall_noop", 32'(stall), 32'd0);
    end else if (!aligned) begin
      check_eq("stall_misal", 32'(stall), 32'd0);
      exp_mis = 1'b1;
    end else begin
      check_eq("stall_issue", 32'(stall), 32'd1);
      last_stalls = 1;
      exp_req     = 1'b1;
      for (int i = 0; i <= wt; i++) begin
        cycle_begin();
        if (i == 0) last_req_cyc = cyc;
        check_eq("dmem_addr", bus.dmem_addr, {a[31:2], 2'b00});
        check_eq("dmem_we", 32'(bus.dmem_we), 32'(st));
        check_eq("dmem_wstrb", 32'(bus.dmem_wstrb), st ? 32'(model_wstrb(f3, a)) : 32'd0);
        if (st) check_eq("dmem_wdata", bus.dmem_wdata, model_wdata(f3, sd));
        exec_valid     = 1'($urandom);
        mem_read       = 1'($urandom);
        mem_write      = 1'($urandom);
        funct3         = 3'($urandom);
        addr           = $urandom;
        store_data     = $urandom;
        bus.dmem_ack   = (i == wt);
        bus.dmem_rdata = (i == wt) ? rdv : $urandom;
        #1;
        check_eq("stall_req", 32'(stall), (i == wt) ? 32'd0 : 32'd1);
        if (stall) last_stalls++;
      end
      check_eq("stall_cycles", 32'(last_stalls), 32'(wt + 1));
      exp_req = 1'b0;
      if (!st) begin
        exp_data = model_load(f3, a, rdv);
        exp_lv   = 1'b1;
      end
    end
  endtask

  logic [2:0] legal_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    int          first_req;
    logic        r_ev;
    logic        r_rd;
    logic        r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_a;

    checks         = 0;
    failures       = 0;
    cyc            = 0;
    last_req_cyc   = 0;
    last_stalls    = 0;
    exp_req        = 1'b0;
    exp_lv         = 1'b0;
    exp_mis        = 1'b0;
    exp_data       = 32'd0;
    rst_n          = 1'b0;
    exec_valid     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    funct3         = 3'd0;
    addr           = 32'd0;
    store_data     = 32'd0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;

    // Reset state; a valid op offered during reset must not stall.
    cycle_begin();
    check_eq("rst_we", 32'(bus.dmem_we), 32'd0);
    check_eq("rst_addr", bus.dmem_addr, 32'd0);
    check_eq("rst_wstrb", 32'(bus.dmem_wstrb), 32'd0);
    check_eq("rst_wdata", bus.dmem_wdata, 32'd0);
    exec_valid = 1'b1;
    mem_read   = 1'b1;
    funct3     = 3'b010;
    addr       = 32'h40;
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    cycle_begin();
    rst_n = 1'b1;

    // Directed vectors.
    do_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h1234_56A5, 0, 32'd0);
    check_eq("tp_sb_stall", 32'(last_stalls), 32'd1);
    do_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h2, 32'd0, 0, 32'h80FF_7F01);
    idle();
    check_eq("tp_lb", data_mem_out, 32'hFFFF_FFFF);
    do_op(1'b1, 1'b1, 1'b0, 3'b100, 32'h2, 32'd0, 0, 32'h80FF_7F01);
    idle();
    check_eq("tp_lbu", data_mem_out, 32'h0000_00FF);
    do_op(1'b1, 1'b1, 1'b0, 3'b101, 32'h2, 32'd0, 0, 32'h80FF_7F01);
    idle();
    check_eq("tp_lhu", data_mem_out, 32'h0000_80FF);
    do_op(1'b1, 1'b1, 1'b0, 3'b001, 32'h0, 32'd0, 0, 32'h80FF_7F01);
    idle();
    check_eq("tp_lh", data_mem_out, 32'h0000_7F01);
    do_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h6, 32'd0, 0, 32'd0);
    do_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h1, 32'hFFFF, 0, 32'd0);
    idle();
    check_eq("tp_misal_hold", data_mem_out, 32'h0000_7F01);
    do_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 3, 32'hDEAD_BEEF);
    check_eq("tp_lw_stall4", 32'(last_stalls), 32'd4);
    idle();
    check_eq("tp_lw_wait", data_mem_out, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b1, 1'b0, 3'b011, 32'h8, 32'd0, 0, 32'd0);
    do_op(1'b1, 1'b0, 1'b1, 3'b100, 32'h8, 32'h55, 0, 32'd0);

    // Reset while a request is outstanding, then a late ack in IDLE.
    cycle_begin();
    exec_valid     = 1'b1;
    mem_read       = 1'b1;
    mem_write      = 1'b0;
    funct3         = 3'b010;
    addr           = 32'h40;
    bus.dmem_rdata = $urandom;
    #1;
    check_eq("rst_issue_stall", 32'(stall), 32'd1);
    exp_req = 1'b1;
    cycle_begin();
    rst_n = 1'b0;
    #1;
    check_eq("rst_stall_forced", 32'(stall), 32'd0);
    exp_req  = 1'b0;
    exp_data = 32'd0;
    cycle_begin();
    rst_n = 1'b1;
    check_eq("rst_req_we", 32'(bus.dmem_we), 32'd0);
    check_eq("rst_req_addr", bus.dmem_addr, 32'd0);
    check_eq("rst_req_wstrb", 32'(bus.dmem_wstrb), 32'd0);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hCAFE_F00D;
    #1;
    check_eq("late_ack_stall", 32'(stall), 32'd0);
    idle();

    // Back-to-back SW then LW; both read and write set executes as a store.
    do_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h80, 32'h0BAD_F00D, 0, 32'd0);
    first_req = last_req_cyc;
    do_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 0, 32'h1357_9BDF);
    check_eq("b2b_gap", 32'(last_req_cyc - first_req), 32'd2);
    do_op(1'b1, 1'b1, 1'b1, 3'b001, 32'h86, 32'h0000_A55A, 1, 32'hFFFF_FFFF);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r_ev = ($urandom_range(0, 9) != 0);
      r_rd = 1'($urandom);
      r_wr = 1'($urandom);
      r_f3 = ($urandom_range(0, 3) != 0) ? legal_tab[$urandom_range(0, 4)] : 3'($urandom);
      r_a  = $urandom;
      if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
      do_op(r_ev, r_rd, r_wr, r_f3, r_a, $urandom, int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
